// File: rtl/approx_div_seq_pkg.sv
`default_nettype none
// ============================================================================
// approx_pkg : shared widths, FSM encoding and divide-by-zero code for
//              the approximate divider family.
// Rev 1.0
// ============================================================================
package approx_pkg;
    localparam int DIV_DW = 16;
    localparam int DIV_SW = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DIV_DW-1:0] DIV0_QUOT = 16'hFFFF;
endpackage
`default_nettype wire

// File: rtl/approx_div_seq_if.sv
`default_nettype none
// ============================================================================
// approx_div_seq_if : operand and result valid/ready channels of the divider.
// Rev 1.0
// ============================================================================
interface approx_div_seq_if;
    import approx_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DIV_DW-1:0] dividend;
    logic [DIV_SW-1:0] divisor;
    logic              out_valid;
    logic              out_ready;
    logic [DIV_DW-1:0] quot;
    logic [DIV_SW-1:0] rem;
    logic              div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, rem, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, rem, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/approx_div_seq_div_step.sv
`default_nettype none
// ============================================================================
// div_step : one combinational restoring-division step.
// Rev 1.0
// ============================================================================
module div_step
    import approx_pkg::*;
(
    input  wire logic [DIV_SW:0]   rem_in,
    input  wire logic              bit_in,
    input  wire logic [DIV_SW-1:0] divisor,
    output logic      [DIV_SW:0]   rem_out,
    output logic                   q_bit
);
    logic [DIV_SW+1:0] w_shift;
    logic [DIV_SW+1:0] w_diff;

    // rem_in is always below divisor, so the MSB of the difference is a true borrow
    assign w_shift = {rem_in, bit_in};
    assign w_diff  = w_shift - {2'b00, divisor};
    assign q_bit   = ~w_diff[DIV_SW+1];
    assign rem_out = q_bit ? w_diff[DIV_SW:0] : w_shift[DIV_SW:0];
endmodule
`default_nettype wire

// File: rtl/approx_div_seq.sv
`default_nettype none
// ============================================================================
// approx_div_seq : sequential restoring divider, 16-bit / 8-bit, with the
//                  low SKIP_LSB quotient bits forced to zero.
// Rev 1.0
// ============================================================================
module approx_div_seq
    import approx_pkg::*;
#(
    parameter int SKIP_LSB = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    approx_div_seq_if.slave   bus
);
    localparam int N_ITER = DIV_DW - SKIP_LSB;
    localparam int CNT_W  = $clog2(DIV_DW + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DIV_DW-1:0] r_dvd;
    logic [DIV_DW-2:0] r_q;
    logic [DIV_SW:0]   r_prem;
    logic [DIV_SW-1:0] r_dsr;
    logic [DIV_DW-1:0] r_quot;
    logic [DIV_SW-1:0] r_rem;
    logic              r_dbz;

    logic [DIV_SW:0]   w_rem_next;
    logic              w_q_bit;
    logic [DIV_DW-1:0] w_q_next;

    div_step u_step (
        .rem_in  (r_prem),
        .bit_in  (r_dvd[DIV_DW-1]),
        .divisor (r_dsr),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

    assign w_q_next = {r_q, w_q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_q     <= '0;
            r_prem  <= '0;
            r_dsr   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_dvd  <= bus.dividend;
                        r_dsr  <= bus.divisor;
                        r_q    <= '0;
                        r_prem <= '0;
                        r_cnt  <= '0;
                        if (bus.divisor == '0) begin
                            r_state <= DONE;
                            r_quot  <= DIV0_QUOT;
                            r_rem   <= '0;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            r_dbz   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    // Only the top N_ITER dividend bits ever reach the step,
                    // which is exactly dividend >> SKIP_LSB.
                    r_dvd  <= {r_dvd[DIV_DW-2:0], 1'b0};
                    r_q    <= w_q_next[DIV_DW-2:0];
                    r_prem <= w_rem_next;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        r_quot  <= w_q_next << SKIP_LSB;
                        r_rem   <= w_rem_next[DIV_SW-1:0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.quot        = r_quot;
    assign bus.rem         = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_approx_div_seq.sv
`default_nettype none
// ============================================================================
// tb_approx_div_seq : directed and random checks of approx_div_seq for
//                     SKIP_LSB = 0 and SKIP_LSB = 4 against an arithmetic model.
// Rev 1.0
// ============================================================================
module tb_approx_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    approx_div_seq_if b0 ();
    approx_div_seq_if b4 ();

    approx_div_seq #(.SKIP_LSB(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    approx_div_seq #(.SKIP_LSB(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int          sel = 0;
    logic        t_in_valid = 1'b0;
    logic        t_out_ready = 1'b0;
    logic [15:0] t_dvd = '0;
    logic [7:0]  t_dsr = '0;

    assign b0.in_valid  = t_in_valid && (sel == 0);
    assign b4.in_valid  = t_in_valid && (sel == 4);
    assign b0.out_ready = t_out_ready && (sel == 0);
    assign b4.out_ready = t_out_ready && (sel == 4);
    assign b0.dividend  = t_dvd;
    assign b4.dividend  = t_dvd;
    assign b0.divisor   = t_dsr;
    assign b4.divisor   = t_dsr;

    logic        o_in_ready, o_out_valid, o_dbz;
    logic [15:0] o_quot;
    logic [7:0]  o_rem;

    always_comb begin
        o_in_ready  = b0.in_ready;
        o_out_valid = b0.out_valid;
        o_quot      = b0.quot;
        o_rem       = b0.rem;
        o_dbz       = b0.div_by_zero;
        if (sel == 4) begin
            o_in_ready  = b4.in_ready;
            o_out_valid = b4.out_valid;
            o_quot      = b4.quot;
            o_rem       = b4.rem;
            o_dbz       = b4.div_by_zero;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: D' = dividend >> skip, quot = (D'/divisor) << skip, rem = D' % divisor.
    function automatic void model(input int dvd, input int dsr, input int skip,
                                  output int q, output int r, output int z);
        int dp;
        if (dsr == 0) begin
            q = 16'hFFFF; r = 0; z = 1;
        end else begin
            dp = dvd >> skip;
            q  = ((dp / dsr) << skip) & 16'hFFFF;
            r  = dp % dsr;
            z  = 0;
        end
    endfunction

    task automatic run_op(input int dvd, input int dsr, input int hold);
        int q, r, z, lat, exp_lat;
        model(dvd, dsr, sel, q, r, z);
        exp_lat = (z != 0) ? 1 : (16 - sel) + 1;
        @(negedge clk);
        check("in_ready_idle", {31'd0, o_in_ready}, 1);
        t_in_valid = 1'b1;
        t_dvd      = dvd[15:0];
        t_dsr      = dsr[7:0];
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        t_in_valid = 1'b0;
        t_dvd      = 16'($urandom);
        t_dsr      = 8'($urandom);
        while (!o_out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, exp_lat);
        check("quot", {16'd0, o_quot}, q);
        check("rem", {24'd0, o_rem}, r);
        check("div_by_zero", {31'd0, o_dbz}, z);
        check("in_ready_busy", {31'd0, o_in_ready}, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, o_out_valid}, 1);
            check("bp_in_ready", {31'd0, o_in_ready}, 0);
            check("bp_quot", {16'd0, o_quot}, q);
            check("bp_rem", {24'd0, o_rem}, r);
            check("bp_dbz", {31'd0, o_dbz}, z);
        end
        t_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_out_ready = 1'b0;
        check("released_valid", {31'd0, o_out_valid}, 0);
        check("released_in_ready", {31'd0, o_in_ready}, 1);
        check("idle_quot_held", {16'd0, o_quot}, q);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready0", {31'd0, b0.in_ready}, 1);
        check("rst_out_valid0", {31'd0, b0.out_valid}, 0);
        check("rst_quot0", {16'd0, b0.quot}, 0);
        check("rst_rem0", {24'd0, b0.rem}, 0);
        check("rst_dbz0", {31'd0, b0.div_by_zero}, 0);
        check("rst_in_ready4", {31'd0, b4.in_ready}, 1);

        sel = 0;
        run_op(1000, 7, 0);
        run_op(65535, 1, 0);
        run_op(65025, 255, 0);
        run_op(1234, 0, 0);
        run_op(10, 3, 0);
        run_op(50000, 200, 20);
        run_op(255, 0, 2);
        run_op(0, 9, 0);
        for (int i = 0; i < 20; i++)
            run_op($urandom_range(0, 65535), (i % 7 == 3) ? 0 : $urandom_range(1, 255),
                   $urandom_range(0, 3));

        sel = 4;
        run_op(1000, 7, 0);
        run_op(65535, 1, 1);
        run_op(15, 16, 0);
        for (int i = 0; i < 15; i++)
            run_op($urandom_range(0, 65535), (i % 6 == 2) ? 0 : $urandom_range(1, 255),
                   $urandom_range(0, 3));

        // Reset during CALC iteration 5: result must be discarded.
        sel = 0;
        @(negedge clk);
        t_in_valid = 1'b1;
        t_dvd      = 16'd40000;
        t_dsr      = 8'd3;
        @(posedge clk);
        @(negedge clk);
        t_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, o_in_ready}, 1);
        check("midrst_out_valid", {31'd0, o_out_valid}, 0);
        check("midrst_quot", {16'd0, o_quot}, 0);
        check("midrst_rem", {24'd0, o_rem}, 0);
        check("midrst_dbz", {31'd0, o_dbz}, 0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (o_out_valid) seen++;
        end
        check("midrst_no_result", seen, 0);
        run_op(100, 10, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
